// File: rtl/uart_echo_display.sv
// UART echo/display: a free-running baud divider, a 7-segment byte shifter,
// and an echo FIFO drained by a handshake FSM into the UART transmitter.
module uart_echo_display #(
    parameter int CLK_DIV      = 27,
    parameter int FIFO_DEPTH   = 16,
    parameter int DISP_BYTES   = 3,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          echo_en,
    input  logic                          ovf_clr,
    output logic                          baudclk16,
    output logic [7:0]                    tx_data,
    output logic                          tx_write,
    input  logic                          tx_ready,
    output logic [8*DISP_BYTES-1:0]       disp_data,
    output logic                          disp_wen,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state_q, state_d;
    logic [DW-1:0]           div_q, div_d;
    logic                    baud_q, baud_d;
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]           count_q, count_d;
    logic [7:0]              mem_q [FIFO_DEPTH];
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_write_q, tx_write_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [8*DISP_BYTES-1:0] disp_q, disp_d;
    logic                    disp_upd_q, disp_upd_d;
    logic                    disp_wen_q, disp_wen_d;
    logic                    ovf_q, ovf_d;
    logic                    full, push, pop, drop;

    // Baud divider; the tick is registered so it lines up with the count value.
    always_comb begin
        div_d  = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        baud_d = (div_d == DW'(CLK_DIV - 1));
    end

    // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle.
    always_comb begin
        full    = (count_q == CW'(FIFO_DEPTH));
        push    = rx_valid && echo_en && (!full || pop);
        drop    = rx_valid && echo_en && full && !pop;
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_comb begin
        disp_d = disp_q;
        if (rx_valid) begin
            disp_d      = disp_q << 8;
            disp_d[7:0] = rx_data;
        end
        disp_upd_d = rx_valid;
        disp_wen_d = disp_upd_q;
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_write_d = 1'b0;
        timer_d    = timer_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && tx_ready) begin
                    pop        = 1'b1;
                    tx_data_d  = mem_q[rd_q];
                    tx_write_d = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                timer_d = TW'(1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never shows busy is assumed to have taken the byte.
                if (!tx_ready)                                state_d = WAIT_DONE;
                else if (timer_q == TW'(BUSY_TIMEOUT - 1))    state_d = IDLE;
                else                                          timer_d = timer_q + 1'b1;
            end
            WAIT_DONE: begin
                if (tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            baud_q     <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_write_q <= 1'b0;
            timer_q    <= '0;
            disp_q     <= '0;
            disp_upd_q <= 1'b0;
            disp_wen_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
            timer_q    <= timer_d;
            disp_q     <= disp_d;
            disp_upd_q <= disp_upd_d;
            disp_wen_q <= disp_wen_d;
            ovf_q      <= ovf_d;
        end
    end

    assign baudclk16  = baud_q;
    assign tx_data    = tx_data_q;
    assign tx_write   = tx_write_q;
    assign disp_data  = disp_q;
    assign disp_wen   = disp_wen_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_uart_echo_display.sv
// Directed bench for uart_echo_display: divider, display shifter, FIFO
// overflow, echo ordering and handshake timing, timeout and reset recovery.
module tb_uart_echo_display;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        echo_en;
    logic        ovf_clr;
    logic        baudclk16;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_ready;
    logic [23:0] disp_data;
    logic        disp_wen;
    logic [2:0]  fifo_count;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic       tx_mode;   // 1 = transmitter model drives tx_ready
    logic       tx_force;
    int         busy_cnt;
    logic [7:0] log_q[$];
    int         ts_q[$];

    uart_echo_display #(
        .CLK_DIV(27), .FIFO_DEPTH(4), .DISP_BYTES(3), .BUSY_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .echo_en(echo_en), .ovf_clr(ovf_clr), .baudclk16(baudclk16),
        .tx_data(tx_data), .tx_write(tx_write), .tx_ready(tx_ready),
        .disp_data(disp_data), .disp_wen(disp_wen), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tx_ready = tx_mode ? (busy_cnt == 0) : tx_force;

    // Transmitter model: busy for 100 cycles after each write strobe.
    always @(negedge clk) begin
        if (reset)              busy_cnt <= 0;
        else if (tx_write)      busy_cnt <= 100;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (tx_write) begin
            log_q.push_back(tx_data);
            ts_q.push_back(cyc);
        end
    end

    typedef struct {
        logic [7:0]  rx;
        logic        echo;
        logic [23:0] disp;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " strobe count"}, log_q.size(), n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first_tick, second_tick, bad;
        vecs[0] = '{8'hA1, 1'b1, 24'h0000A1, 3'd1, 1'b0};
        vecs[1] = '{8'hB2, 1'b0, 24'h00A1B2, 3'd1, 1'b0};
        vecs[2] = '{8'hC3, 1'b1, 24'hA1B2C3, 3'd2, 1'b0};
        vecs[3] = '{8'hD4, 1'b1, 24'hB2C3D4, 3'd3, 1'b0};
        vecs[4] = '{8'hE5, 1'b1, 24'hC3D4E5, 3'd4, 1'b0};
        vecs[5] = '{8'hF6, 1'b1, 24'hD4E5F6, 3'd4, 1'b1};
        vecs[6] = '{8'h07, 1'b0, 24'hE5F607, 3'd4, 1'b1};

        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; echo_en = 1'b0;
        ovf_clr = 1'b0; tx_mode = 1'b0; tx_force = 1'b0;

        // Reset state and no divider tick while held in reset
        idle(3);
        check("rst tx_write", tx_write, 0);
        check("rst tx_data", tx_data, 0);
        check("rst disp_data", disp_data, 0);
        check("rst disp_wen", disp_wen, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst overflow", overflow, 0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (baudclk16 !== 1'b0) bad++;
        end
        check("no tick in reset", bad, 0);

        // Divider: cycle 1 is the one in which reset is released
        reset = 1'b0;
        first_tick = 0; second_tick = 0; bad = 0;
        for (int i = 2; i <= 60; i++) begin
            @(negedge clk);
            if (baudclk16 === 1'b1) begin
                if (first_tick == 0)       first_tick = i;
                else if (second_tick == 0) second_tick = i;
                else                       bad++;
            end
        end
        check("first tick cycle", first_tick, 27);
        check("second tick cycle", second_tick, 54);
        check("extra ticks", bad, 0);

        // Display shift, FIFO fill and overflow with the transmitter busy
        foreach (vecs[i]) begin
            echo_en  = vecs[i].echo;
            rx_data  = vecs[i].rx;
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            check($sformatf("vec%0d disp", i), disp_data, vecs[i].disp);
            check($sformatf("vec%0d count", i), fifo_count, vecs[i].cnt);
            check($sformatf("vec%0d ovf", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d wen early", i), disp_wen, 0);
            @(negedge clk);
            check($sformatf("vec%0d wen", i), disp_wen, 1);
            @(negedge clk);
            check($sformatf("vec%0d wen late", i), disp_wen, 0);
        end

        // Overflow clear, then clear colliding with a dropped byte
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("ovf cleared", overflow, 0);
        echo_en = 1'b1; ovf_clr = 1'b1;
        send(8'h99);
        ovf_clr = 1'b0;
        check("ovf set wins clr", overflow, 1);
        check("drop count", fifo_count, 4);
        check("drop disp", disp_data, 24'hF60799);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("ovf cleared 2", overflow, 0);

        // Release the transmitter: queued bytes drain in arrival order
        log_q.delete(); ts_q.delete();
        echo_en = 1'b0;
        tx_mode = 1'b1;
        wait_strobes(4, 800, "drain");
        check("drain b0", log_q[0], 8'hA1);
        check("drain b1", log_q[1], 8'hC3);
        check("drain b2", log_q[2], 8'hD4);
        check("drain b3", log_q[3], 8'hE5);
        idle(150);
        check("drain total", log_q.size(), 4);
        check("drain count", fifo_count, 0);

        // Echo order and handshake spacing against a 100-cycle-busy transmitter
        log_q.delete(); ts_q.delete();
        echo_en = 1'b1;
        send(8'h41); send(8'h42); send(8'h43);
        wait_strobes(3, 600, "echo");
        check("echo b0", log_q[0], 8'h41);
        check("echo b1", log_q[1], 8'h42);
        check("echo b2", log_q[2], 8'h43);
        check("echo disp", disp_data, 24'h414243);
        check("echo gap 1", ts_q[1] - ts_q[0], 102);
        check("echo gap 2", ts_q[2] - ts_q[1], 102);
        idle(150);
        check("echo total", log_q.size(), 3);

        // Full FIFO: push and pop in the same cycle
        log_q.delete(); ts_q.delete();
        tx_mode = 1'b0; tx_force = 1'b0;
        send(8'h51); send(8'h52); send(8'h53); send(8'h54);
        check("full count", fifo_count, 4);
        tx_force = 1'b1;
        send(8'h55);
        tx_mode = 1'b1;
        check("simul count", fifo_count, 4);
        check("simul ovf", overflow, 0);
        check("simul tx_write", tx_write, 1);
        check("simul tx_data", tx_data, 8'h51);
        wait_strobes(5, 900, "simul");
        for (int i = 0; i < 5; i++) check($sformatf("simul b%0d", i), log_q[i], 8'h51 + i);
        idle(150);

        // Timeout: transmitter never shows busy
        log_q.delete(); ts_q.delete();
        tx_mode = 1'b0; tx_force = 1'b1;
        send(8'h61); send(8'h62);
        wait_strobes(2, 300, "timeout");
        check("timeout b0", log_q[0], 8'h61);
        check("timeout b1", log_q[1], 8'h62);
        check("timeout gap", ts_q[1] - ts_q[0], 65);
        idle(80);

        // Reset while waiting for the transmitter with three bytes queued
        log_q.delete(); ts_q.delete();
        tx_mode = 1'b1;
        send(8'h71); send(8'h72); send(8'h73); send(8'h74);
        wait_strobes(1, 50, "pre-reset");
        idle(20);
        check("pre-reset count", fifo_count, 3);
        check("pre-reset disp", disp_data, 24'h727374);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst tx_write", tx_write, 0);
        check("mid rst tx_data", tx_data, 0);
        check("mid rst disp", disp_data, 0);
        check("mid rst wen", disp_wen, 0);
        check("mid rst count", fifo_count, 0);
        check("mid rst ovf", overflow, 0);
        check("mid rst baud", baudclk16, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post rst tx_write", tx_write, 0);
        idle(300);
        check("post rst strobes", log_q.size(), 1);
        check("post rst count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_echo_display.md
UART_ECHO_DISPLAY -- requirements
Module: uart_echo_display

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27: clk cycles per baudclk16 tick, legal 2..1024.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: echo FIFO entries, power of two, 2..256.
REQ-003 SHALL have parameter DISP_BYTES, default 3: bytes shown on the display bus, 1..4.
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 64: clk cycles allowed for tx_ready to fall after tx_write.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports in this order:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  received byte from the UART receiver.
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
echo_en  input  1  1 = received bytes queue for echo; 0 = display only.
ovf_clr  input  1  one-cycle pulse; clears overflow.
baudclk16  output  1  one-cycle tick every CLK_DIV clk cycles, free-running.
tx_data  output  8  byte presented to the UART transmitter.
tx_write  output  1  one-cycle write strobe to the transmitter.
tx_ready  input  1  transmitter idle (1) or busy (0).
disp_data  output  8*DISP_BYTES  last DISP_BYTES received bytes, newest in bits [7:0].
disp_wen  output  1  one-cycle write enable for the 7-segment interface.
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-006 Baud divider SHALL count 0..CLK_DIV-1, wrap to 0, and assert baudclk16 for exactly the cycle in which the count equals CLK_DIV-1; it runs regardless of tx_ready.
REQ-007 On rx_valid, disp_data SHALL shift left by 8 with rx_data entering [7:0] and the oldest byte discarded; disp_wen SHALL pulse in the cycle after disp_data updates.
REQ-008 On rx_valid with echo_en=1 and FIFO not full, rx_data SHALL be pushed; fifo_count SHALL reflect the push on the next cycle.
REQ-009 On rx_valid with echo_en=1 and FIFO full, the byte SHALL NOT be pushed, overflow SHALL set to 1, and the display SHALL still update.
REQ-010 overflow SHALL clear on ovf_clr; if ovf_clr and a dropping rx_valid occur in the same cycle, overflow SHALL end at 1.
REQ-011 A push and a pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-012 Read and write pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL leave the FIFO in arrival order.
REQ-013 Echo FSM states: IDLE, WRITE, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE -> WRITE when the FIFO is non-empty and tx_ready=1; tx_data is loaded from the FIFO head and the entry is popped in that transition cycle.
REQ-015 WRITE SHALL assert tx_write for exactly one cycle with tx_data stable, then go to WAIT_BUSY.
REQ-016 WAIT_BUSY -> WAIT_DONE when tx_ready=0; WAIT_BUSY -> IDLE after BUSY_TIMEOUT cycles without tx_ready=0, treating the byte as sent.
REQ-017 WAIT_DONE -> IDLE when tx_ready=1; the earliest next tx_write SHALL come 2 cycles after tx_ready rises.
REQ-018 tx_data SHALL hold its value from WRITE until the next IDLE -> WRITE transition.
REQ-019 Clearing echo_en SHALL NOT flush the FIFO or abort a byte in flight; queued bytes still drain.

Reset
REQ-020 Reset SHALL take priority over all other inputs, including in mid-transmission.
REQ-021 On reset: FSM=IDLE, divider=0, pointers=0, fifo_count=0, tx_write=0, tx_data=0x00, disp_data=0, disp_wen=0, overflow=0, baudclk16=0.
REQ-022 A byte queued or in flight at reset SHALL be discarded, and no tx_write SHALL be issued in the cycle after reset deasserts.

Verification
REQ-023 Divider: CLK_DIV=27, reset released -> first baudclk16 at cycle 27, then every 27 cycles; no tick while reset=1.
REQ-024 Echo order: echo_en=1, bytes 0x41, 0x42, 0x43; transmitter model busy 100 cycles per byte -> tx_write carries 0x41, 0x42, 0x43 in order, one strobe each; disp_data=0x414243.
REQ-025 Overflow: FIFO_DEPTH=4, tx_ready held 0, 6 bytes 0x10..0x15 -> fifo_count=4, overflow=1; after release, echo is 0x10..0x13; ovf_clr -> overflow=0.
REQ-026 Simultaneous events: FIFO full while the FSM pops in the same cycle as rx_valid -> count stays 4, overflow stays 0, new byte is echoed last.
REQ-027 Timeout: tx_ready stuck at 1 -> FSM returns to IDLE BUSY_TIMEOUT cycles after tx_write and sends the next byte.
REQ-028 Reset mid-operation: reset asserted in WAIT_DONE with 3 bytes queued -> all REQ-021 values next cycle; no further tx_write.
